fifo_rd_ctrl: RTL and testbench

- Read-side controller for the sample FIFO RAM. It owns the read pointer and drives the RAM's asynchronous read address.
- It compares its pointer against the writer's pointer to derive empty and fill level, and presents samples downstream through a registered valid/ready stream.
- It returns its read pointer to the write side so the writer can compute full.
- It sits between the ADC-side FIFO RAM and the display/UART consumer, in the same clock domain as the writer.

---
 rtl/fifo_rd_ctrl.sv | 87 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rd_ctrl
//  Description : Read-side controller for the sample FIFO RAM. Owns the read
//                pointer, drives the RAM read address, derives empty/level
//                from the writer's pointer and presents samples through a
//                registered valid/ready output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_ctrl #(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [ADDR_SIZE:0]   w_ptr_i,
    output logic [ADDR_SIZE:0]   r_ptr_o,
    output logic [ADDR_SIZE-1:0] r_addr_o,
    input  logic [DATA_SIZE-1:0] r_data_i,
    output logic [DATA_SIZE-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    input  logic                 flush_i,
    output logic                 empty_o,
    output logic [ADDR_SIZE:0]   level_o,
    output logic                 overrun_o
);

    // Level value that means the RAM is exactly full; anything above it means
    // the writer has lapped the reader.
    localparam logic [ADDR_SIZE:0] C_DEPTH = {1'b1, {ADDR_SIZE{1'b0}}};

    logic [ADDR_SIZE:0]   r_ptr;
    logic [DATA_SIZE-1:0] r_dout;
    logic                 r_valid;
    logic                 r_overrun;

    logic                 w_empty;
    logic [ADDR_SIZE:0]   w_level;
    logic                 w_load;

    // The extra wrap bit keeps empty and full distinguishable, so a plain
    // modular subtraction gives the true unread count across any wraps.
    assign w_empty = (w_ptr_i == r_ptr);
    assign w_level = w_ptr_i - r_ptr;
    // Refill the output stage whenever it is free or being drained this cycle.
    assign w_load  = !w_empty && (!r_valid || ready_i) && !flush_i;

    // Read pointer and output stage: flush beats load, load beats plain consume.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_ptr   <= w_ptr_i;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_dout  <= r_data_i;
            r_ptr   <= r_ptr + 1'b1;
            r_valid <= 1'b1;
        end else if (ready_i && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun flag: set when the writer lapped us, cleared only by flush.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_overrun <= 1'b0;
        end else if (flush_i) begin
            r_overrun <= 1'b0;
        end else if (w_level > C_DEPTH) begin
            r_overrun <= 1'b1;
        end
    end

    assign r_ptr_o   = r_ptr;
    assign r_addr_o  = r_ptr[ADDR_SIZE-1:0];
    assign data_o    = r_dout;
    assign valid_o   = r_valid;
    assign empty_o   = w_empty;
    assign level_o   = w_level;
    assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rd_ctrl
//  Description : Self-checking bench for fifo_rd_ctrl. A RAM array and a
//                writer live in the bench; a queue-based model of the unread
//                samples and output stage predicts every DUT output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int DW = 12;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW:0]   w_ptr = '0;
    logic [AW:0]   r_ptr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready = 1'b0;
    logic          flush = 1'b0;
    logic          empty;
    logic [AW:0]   level;
    logic          overrun;

    logic [DW-1:0] mem [256];

    // Model state: samples written but not yet taken into the output stage.
    logic [DW-1:0] pending [$];
    logic [DW-1:0] got [$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [AW:0]   m_rptr;
    logic          m_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_rd_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .w_ptr_i   (w_ptr),
        .r_ptr_o   (r_ptr),
        .r_addr_o  (r_addr),
        .r_data_i  (r_data),
        .data_o    (data),
        .valid_o   (valid),
        .ready_i   (ready),
        .flush_i   (flush),
        .empty_o   (empty),
        .level_o   (level),
        .overrun_o (overrun)
    );

    assign r_data = mem[r_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_rptr  = '0;
        m_ovr   = 1'b0;
    endtask

    task automatic compare_model();
        chk("valid", 32'(valid), 32'(m_valid));
        chk("data", 32'(data), 32'(m_data));
        chk("r_ptr", 32'(r_ptr), 32'(m_rptr));
        chk("r_addr", 32'(r_addr), 32'(m_rptr[AW-1:0]));
        chk("empty", 32'(empty), 32'(pending.size() == 0));
        chk("level", 32'(level), 32'(pending.size() & 511));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // Advance the model by one clock using the inputs held during that cycle.
    task automatic model_edge();
        if (flush) begin
            pending.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_rptr  = w_ptr;
        end else begin
            if (pending.size() > 256) m_ovr = 1'b1;
            if (pending.size() != 0 && (!m_valid || ready)) begin
                m_data  = pending.pop_front();
                m_valid = 1'b1;
                m_rptr  = m_rptr + 1'b1;
            end else if (ready && m_valid) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock of stimulus: drive, check at negedge, step model at posedge.
    task automatic step(input bit wr, input logic [DW-1:0] val, input bit rdy, input bit fl);
        ready = rdy;
        flush = fl;
        if (wr) begin
            mem[w_ptr[AW-1:0]] = val;
            w_ptr = w_ptr + 1'b1;
            pending.push_back(val);
        end
        @(negedge clk);
        compare_model();
        if (valid && ready) got.push_back(data);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        w_ptr = '0;
        ready = 1'b0;
        flush = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int            written;
        int            cyc;
        int            errs;
        int            toggles;
        logic          prev_msb;
        bit            wr;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        model_reset();
        @(posedge clk);
        #1;
        // Reset state, pinned with literals.
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_rptr", 32'(r_ptr), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst_n = 1'b1;

        // Three back-to-back samples with the consumer always ready.
        step(1, 12'h001, 1, 0);
        chk("t1_valid1", 32'(valid), 1);
        chk("t1_d1", 32'(data), 32'h001);
        step(1, 12'h002, 1, 0);
        chk("t1_d2", 32'(data), 32'h002);
        step(1, 12'h003, 1, 0);
        chk("t1_d3", 32'(data), 32'h003);
        step(0, 12'h000, 1, 0);
        chk("t1_valid_end", 32'(valid), 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_level", 32'(level), 0);

        // Fill the whole RAM while stalled, then drain without bubbles.
        do_reset();
        for (int i = 0; i < 256; i++) step(1, 12'(32'h100 + i), 0, 0);
        chk("t2_valid", 32'(valid), 1);
        chk("t2_first", 32'(data), 32'h100);
        chk("t2_level", 32'(level), 255);
        chk("t2_ovr", 32'(overrun), 0);
        for (int i = 0; i < 255; i++) step(0, 12'h000, 1, 0);
        chk("t2_rptr", 32'(r_ptr), 256);
        chk("t2_last", 32'(data), 32'h1FF);
        step(0, 12'h000, 1, 0);

        // Backpressure pattern 1,0,0,1 with four samples queued.
        do_reset();
        got.delete();
        for (int i = 0; i < 4; i++) step(1, 12'(32'h0A0 + i), 0, 0);
        step(0, 12'h000, 1, 0);
        chk("t3_d_a1", 32'(data), 32'h0A1);
        step(0, 12'h000, 0, 0);
        chk("t3_hold1", 32'(data), 32'h0A1);
        step(0, 12'h000, 0, 0);
        chk("t3_hold2", 32'(data), 32'h0A1);
        step(0, 12'h000, 1, 0);
        chk("t3_d_a2", 32'(data), 32'h0A2);
        step(0, 12'h000, 1, 0);
        step(0, 12'h000, 1, 0);
        chk("t3_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("t3_seq", 32'(got[i]), 32'h0A0 + 32'(i));

        // Wrap: 600 counter samples with random backpressure.
        do_reset();
        got.delete();
        written  = 0;
        cyc      = 0;
        toggles  = 0;
        prev_msb = r_ptr[AW];
        while ((written < 600 || pending.size() != 0 || valid) && cyc < 6000) begin
            wr = (written < 600) && (pending.size() < 200) && ($urandom_range(0, 3) != 0);
            step(wr, 12'(written), 1'($urandom_range(0, 1)), 0);
            if (wr) written++;
            if (r_ptr[AW] != prev_msb) toggles++;
            prev_msb = r_ptr[AW];
            cyc++;
        end
        chk("t4_timeout", 32'(cyc < 6000), 1);
        chk("t4_count", 32'(got.size()), 600);
        errs = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] !== 12'(i)) errs++;
        chk("t4_seq_errs", 32'(errs), 0);
        chk("t4_msb_toggles", 32'(toggles), 2);
        chk("t4_rptr", 32'(r_ptr), 88);

        // Overrun then flush.
        do_reset();
        for (int i = 0; i < 258; i++) step(1, 12'(32'h300 + i), 0, 0);
        chk("t5_ovr", 32'(overrun), 1);
        chk("t5_held", 32'(data), 32'h300);
        step(0, 12'h000, 0, 1);
        chk("t5_f_valid", 32'(valid), 0);
        chk("t5_f_ovr", 32'(overrun), 0);
        chk("t5_f_rptr", 32'(r_ptr), 258);
        chk("t5_f_empty", 32'(empty), 1);
        chk("t5_f_data", 32'(data), 32'h300);
        step(0, 12'h000, 1, 0);

        // Asynchronous reset between edges while a sample is held.
        do_reset();
        step(1, 12'h055, 0, 0);
        step(1, 12'h066, 0, 0);
        chk("t6_pre_valid", 32'(valid), 1);
        chk("t6_pre_rptr", 32'(r_ptr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(valid), 0);
        chk("t6_rptr", 32'(r_ptr), 0);
        chk("t6_data", 32'(data), 0);
        w_ptr = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 12'h000, 1, 0);
        step(1, 12'h077, 1, 0);
        chk("t6_after", 32'(data), 32'h077);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
